counter_countdown: RTL and testbench

//  Down-counting timer that complements the up-counter in the Counter library.

---
 rtl/counter_countdown_pkg.sv | 19 +
 rtl/counter_countdown_if.sv | 26 ++
 rtl/counter_countdown_saturate.sv | 13 +
 rtl/counter_countdown.sv | 72 +++++++
 tb/tb_counter_countdown.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/counter_countdown_pkg.sv
// Shared types and helpers for the countdown timer: state encoding, default sizing
// and a saturating clamp for load values.
package counter_countdown_pkg;

    localparam int CD_MAX   = 12;
    localparam int CD_WIDTH = $clog2(CD_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } Counter_countdown_state_T;

    function automatic logic [CD_WIDTH-1:0] sat(input logic [CD_WIDTH-1:0] d,
                                                input logic [CD_WIDTH-1:0] max_v);
        return (d > max_v) ? max_v : d;
    endfunction

endpackage

// File: rtl/counter_countdown_if.sv
// Load/enable/status bundle between a countdown timer and whoever drives it.
interface counter_countdown_if
    import counter_countdown_pkg::*;
#(
    parameter int WIDTH = CD_WIDTH
);
    logic [WIDTH-1:0] d_i;
    logic             load_i;
    logic             enable_i;
    logic             periodic_i;
    logic [WIDTH-1:0] q_o;
    logic             zero_o;
    logic             expire_o;
    logic             running_o;
    logic             done_o;

    modport master (
        output d_i, load_i, enable_i, periodic_i,
        input  q_o, zero_o, expire_o, running_o, done_o
    );

    modport slave (
        input  d_i, load_i, enable_i, periodic_i,
        output q_o, zero_o, expire_o, running_o, done_o
    );
endinterface

// File: rtl/counter_countdown_saturate.sv
// Combinational clamp of a load value to MAX; the compare is done at full width so
// it stays correct when MAX is not of the form 2^n-1.
module counter_countdown_saturate #(
    parameter int MAX   = 12,
    parameter int WIDTH = $clog2(MAX + 1)
) (
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    assign q_o = (d_i > MAX_W) ? MAX_W : d_i;
endmodule

// File: rtl/counter_countdown.sv
// Down-counting timer: loads a saturated value, decrements on enabled cycles and
// pulses expire at terminal count, either stopping (one-shot) or re-arming (periodic).
module counter_countdown
    import counter_countdown_pkg::*;
#(
    parameter int MAX = CD_MAX
) (
    input  logic                clk,
    input  logic                rst,
    counter_countdown_if.slave  bus
);
    localparam int WIDTH = $clog2(MAX + 1);

    Counter_countdown_state_T state_q, state_d;
    logic [WIDTH-1:0]         q_q, q_d;
    logic [WIDTH-1:0]         reload_q, reload_d;
    logic                     expire_q, expire_d;
    logic [WIDTH-1:0]         d_sat;

    counter_countdown_saturate #(
        .MAX   (MAX),
        .WIDTH (WIDTH)
    ) u_sat (
        .d_i (bus.d_i),
        .q_o (d_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            q_q      <= '0;
            reload_q <= '0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        expire_d = 1'b0;
        if (bus.load_i) begin
            reload_d = d_sat;
            q_d      = d_sat;
            state_d  = (d_sat != '0) ? RUN : IDLE;
        end else if (state_q == RUN && bus.enable_i) begin
            if (q_q > WIDTH'(1)) begin
                q_d = q_q - WIDTH'(1);
            end else begin
                // Terminal step: count reached the end of this period.
                expire_d = 1'b1;
                if (bus.periodic_i) begin
                    q_d = reload_q;
                end else begin
                    q_d     = '0;
                    state_d = DONE;
                end
            end
        end
    end

    assign bus.q_o       = q_q;
    assign bus.zero_o    = (q_q == '0);
    assign bus.expire_o  = expire_q;
    assign bus.running_o = (state_q == RUN);
    assign bus.done_o    = (state_q == DONE);
endmodule

// File: tb/tb_counter_countdown.sv
// Randomized and directed bench for counter_countdown against a behavioural timer model.
module tb_counter_countdown;
    localparam int MAX = 12;

    logic clk;
    logic rst;

    counter_countdown_if #(.WIDTH(4)) bus ();

    counter_countdown #(.MAX(MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_seen = 0;

    // Model: remaining count, value to re-arm from, mode 0=idle 1=armed 2=finished.
    int m_q      = 0;
    int m_reload = 0;
    int m_mode   = 0;
    int m_exp    = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic l, input int dv,
                              input logic e, input logic p);
        if (r) begin
            m_q = 0; m_reload = 0; m_mode = 0; m_exp = 0;
        end else if (l) begin
            m_reload = (dv > MAX) ? MAX : dv;
            m_q      = m_reload;
            m_mode   = (m_reload != 0) ? 1 : 0;
            m_exp    = 0;
        end else if (m_mode == 1 && e) begin
            m_q = m_q - 1;
            m_exp = (m_q == 0) ? 1 : 0;
            if (m_q == 0) begin
                if (p) m_q = m_reload;
                else   m_mode = 2;
            end
        end else begin
            m_exp = 0;
        end
    endtask

    task automatic step(input logic r, input logic l, input logic [3:0] dv,
                        input logic e, input logic p);
        rst            = r;
        bus.load_i     = l;
        bus.d_i        = dv;
        bus.enable_i   = e;
        bus.periodic_i = p;
        @(posedge clk);
        model_edge(r, l, int'(dv), e, p);
        #1;
        if (bus.expire_o) exp_seen++;
        check("q",       32'(bus.q_o),       m_q);
        check("zero",    32'(bus.zero_o),    (m_q == 0) ? 1 : 0);
        check("expire",  32'(bus.expire_o),  m_exp);
        check("running", 32'(bus.running_o), (m_mode == 1) ? 1 : 0);
        check("done",    32'(bus.done_o),    (m_mode == 2) ? 1 : 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.load_i = 1'b0; bus.d_i = '0; bus.enable_i = 1'b0; bus.periodic_i = 1'b0;

        // Reset dominates a simultaneous load.
        exp_seen = 0;
        step(1, 1, 4'd5, 0, 0);
        step(1, 1, 4'd5, 0, 0);
        check("t1_q", 32'(bus.q_o), 0);
        check("t1_zero", 32'(bus.zero_o), 1);
        check("t1_exp_cnt", exp_seen, 0);

        // One-shot countdown from 3.
        step(0, 1, 4'd3, 0, 0);
        check("t2_q_load", 32'(bus.q_o), 3);
        step(0, 0, 4'd0, 1, 0);
        check("t2_q2", 32'(bus.q_o), 2);
        step(0, 0, 4'd0, 1, 0);
        check("t2_q1", 32'(bus.q_o), 1);
        check("t2_noexp", 32'(bus.expire_o), 0);
        step(0, 0, 4'd0, 1, 0);
        check("t2_q0", 32'(bus.q_o), 0);
        check("t2_exp", 32'(bus.expire_o), 1);
        check("t2_done", 32'(bus.done_o), 1);
        step(0, 0, 4'd0, 1, 0);
        step(0, 0, 4'd0, 1, 0);
        check("t2_hold", 32'(bus.q_o), 0);
        check("t2_done_sticky", 32'(bus.done_o), 1);

        // Saturated periodic load.
        step(0, 1, 4'd15, 0, 1);
        check("t3_sat", 32'(bus.q_o), 12);
        exp_seen = 0;
        for (int i = 0; i < 11; i++) step(0, 0, 4'd0, 1, 1);
        check("t3_q1", 32'(bus.q_o), 1);
        step(0, 0, 4'd0, 1, 1);
        check("t3_rearm", 32'(bus.q_o), 12);
        check("t3_exp", 32'(bus.expire_o), 1);
        for (int i = 0; i < 12; i++) step(0, 0, 4'd0, 1, 1);
        check("t3_exp_cnt", exp_seen, 2);

        // Gated decrement, then load beats enable.
        step(0, 1, 4'd4, 0, 0);
        step(0, 0, 4'd0, 1, 0);
        step(0, 0, 4'd0, 0, 0);
        check("t4_hold", 32'(bus.q_o), 3);
        step(0, 0, 4'd0, 1, 0);
        step(0, 0, 4'd0, 0, 0);
        check("t4_q2", 32'(bus.q_o), 2);
        step(0, 1, 4'd9, 1, 0);
        check("t4_load9", 32'(bus.q_o), 9);

        // Load of zero, then reload of one in periodic mode.
        step(0, 1, 4'd0, 0, 0);
        step(0, 0, 4'd0, 1, 0);
        check("t5_idle", 32'(bus.running_o), 0);
        check("t5_zero", 32'(bus.zero_o), 1);
        step(0, 1, 4'd1, 0, 1);
        exp_seen = 0;
        for (int i = 0; i < 4; i++) step(0, 0, 4'd0, 1, 1);
        check("t5_q1", 32'(bus.q_o), 1);
        check("t5_exp_cnt", exp_seen, 4);

        // Reset drops a pending expiry.
        step(0, 1, 4'd2, 0, 0);
        step(0, 0, 4'd0, 1, 0);
        step(1, 0, 4'd0, 1, 0);
        check("t6_q", 32'(bus.q_o), 0);
        check("t6_exp", 32'(bus.expire_o), 0);
        check("t6_done", 32'(bus.done_o), 0);

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 15) == 0),
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
